// File: rtl/encoder_prio_rr_if.sv
// Request/result bundle between a request bank and encoder_prio_rr.
// The master drives samples; the slave (the encoder) returns registered results.
interface encoder_prio_rr_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned W = $clog2(N);

  logic         in_valid;
  logic [N-1:0] req;
  logic         mode;
  logic         out_valid;
  logic [W-1:0] y;
  logic         multi;
  logic         none;
  logic [W-1:0] ptr;

  modport master (
    output in_valid, req, mode,
    input  out_valid, y, multi, none, ptr
  );

  modport slave (
    input  in_valid, req, mode,
    output out_valid, y, multi, none, ptr
  );
endinterface

// File: rtl/encoder_prio_rr.sv
// N:log2(N) priority encoder with registered outputs, multi/none flags and a
// selectable fixed (highest index wins) or round-robin arbitration mode.
module encoder_prio_rr #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst,
  encoder_prio_rr_if.slave   bus
);
  localparam int unsigned W = $clog2(N);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] y_q, y_d;
  logic         multi_q, multi_d;
  logic         none_q, none_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] fix_idx, rr_lo, rr_hi, winner;
  logic         hi_found;

  // Upward scan keeps the highest set bit; downward scan keeps the lowest,
  // both overall (wrap case) and among bits at or above ptr.
  always_comb begin
    fix_idx  = '0;
    rr_lo    = '0;
    rr_hi    = '0;
    hi_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (bus.req[k]) fix_idx = W'(k);
    end
    for (int unsigned k = N; k > 0; k--) begin
      if (bus.req[k-1]) begin
        rr_lo = W'(k - 1);
        if (W'(k - 1) >= ptr_q) begin
          rr_hi    = W'(k - 1);
          hi_found = 1'b1;
        end
      end
    end
    if (bus.mode) winner = hi_found ? rr_hi : rr_lo;
    else          winner = fix_idx;
  end

  always_comb begin
    out_valid_d = bus.in_valid;
    y_d         = y_q;
    multi_d     = multi_q;
    none_d      = none_q;
    ptr_d       = ptr_q;
    if (bus.in_valid) begin
      none_d  = ~|bus.req;
      multi_d = |(bus.req & (bus.req - N'(1)));
      y_d     = none_d ? '0 : winner;
      // N is a power of two, so the W-bit add wraps N-1 back to 0.
      if (bus.mode && !none_d) ptr_d = winner + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      multi_q     <= 1'b0;
      none_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      multi_q     <= multi_d;
      none_q      <= none_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.multi     = multi_q;
  assign bus.none      = none_q;
  assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_encoder_prio_rr.sv
// Scoreboard bench: an N=4 instance checks the legacy 4:2 vectors, an N=8
// instance runs directed and randomised traffic against a behavioural model.
module tb_encoder_prio_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encoder_prio_rr_if #(.N(8)) bus ();
  encoder_prio_rr_if #(.N(4)) bus4 ();

  encoder_prio_rr #(.N(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  encoder_prio_rr #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [2:0] y;
    logic       multi;
    logic       none;
    logic [2:0] ptr;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] y;
    logic       multi;
    int         cyc;
  } exp4_t;

  exp_t  q[$];
  exp4_t q4[$];
  exp_t  last;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    rst_cyc  = -1;
  int    ref_ptr  = 0;
  bit    checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: fixed = highest set index; rr = first set index met walking
  // upward from ptr, wrapping modulo 8.
  task automatic model(input logic [7:0] r, input bit m, output exp_t e);
    int win;
    win     = 0;
    e.multi = ($countones(r) >= 2);
    e.none  = (r == 8'h00);
    if (r != 8'h00) begin
      if (!m) begin
        for (int i = 0; i < 8; i++) if (r[i]) win = i;
      end else begin
        for (int off = 7; off >= 0; off--) if (r[(ref_ptr + off) % 8]) win = (ref_ptr + off) % 8;
        ref_ptr = (win + 1) % 8;
      end
    end
    e.y   = 3'(win);
    e.ptr = 3'(ref_ptr);
    e.cyc = 0;
  endtask

  task automatic drive(input bit v, input logic [7:0] r, input bit m, input bit rs);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = rs;
    bus.in_valid   = v;
    bus.req        = r;
    bus.mode       = m;
    bus4.in_valid  = 1'b0;
    if (rs) begin
      ref_ptr = 0;
      rst_cyc = cyc + 1;
    end else if (v) begin
      model(r, m, e);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic drive4(input logic [3:0] r, input logic [1:0] ey, input bit em);
    exp4_t e;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.req      = r;
    bus4.mode     = 1'b0;
    e.y     = ey;
    e.multi = em;
    e.cyc   = cyc + 1;
    q4.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      if (cyc == rst_cyc) begin
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_multi", 32'(bus.multi), 32'd0);
        check("rst_none", 32'(bus.none), 32'd0);
        check("rst_ptr", 32'(bus.ptr), 32'd0);
        last = '{y: 3'd0, multi: 1'b0, none: 1'b0, ptr: 3'd0, cyc: 0};
      end else if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("latency", 32'(cyc), 32'(e.cyc));
          check("y", 32'(bus.y), 32'(e.y));
          check("multi", 32'(bus.multi), 32'(e.multi));
          check("none", 32'(bus.none), 32'(e.none));
          check("ptr", 32'(bus.ptr), 32'(e.ptr));
          last = e;
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_out_valid: got %0b, expected 1 (cycle %0d)", bus.out_valid, cyc);
          void'(q.pop_front());
        end
        check("hold_y", 32'(bus.y), 32'(last.y));
        check("hold_multi", 32'(bus.multi), 32'(last.multi));
        check("hold_none", 32'(bus.none), 32'(last.none));
        check("hold_ptr", 32'(bus.ptr), 32'(last.ptr));
      end
    end
  end

  always @(negedge clk) begin
    exp4_t e;
    if (checking && bus4.out_valid === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL n4_spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        check("n4_latency", 32'(cyc), 32'(e.cyc));
        check("n4_y", 32'(bus4.y), 32'(e.y));
        check("n4_multi", 32'(bus4.multi), 32'(e.multi));
        check("n4_none", 32'(bus4.none), 32'd0);
      end
    end
  end

  initial begin
    bit         v, m, rs;
    logic [7:0] r;
    last          = '{y: 3'd0, multi: 1'b0, none: 1'b0, ptr: 3'd0, cyc: 0};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.req      = '0;
    bus4.mode     = 1'b0;
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    checking = 1'b1;
    drive(0, 8'h00, 0, 0);

    // Legacy 4:2 vectors on the N=4 instance.
    drive4(4'b0001, 2'd0, 1'b0);
    drive4(4'b0010, 2'd1, 1'b0);
    drive4(4'b0100, 2'd2, 1'b0);
    drive4(4'b1000, 2'd3, 1'b0);
    drive4(4'b0101, 2'd2, 1'b1);
    drive(0, 8'h00, 0, 0);

    // Round-robin walk over a held multi-hot vector.
    for (int i = 0; i < 4; i++) drive(1, 8'h85, 1, 0);
    // No-request in both modes, then an idle gap with held outputs.
    drive(1, 8'h00, 1, 0);
    drive(1, 8'h00, 0, 0);
    drive(0, 8'h3c, 1, 0);
    drive(0, 8'h3c, 1, 0);
    // Pointer retained across mode switches.
    drive(1, 8'h10, 1, 0);
    drive(1, 8'h81, 0, 0);
    drive(1, 8'h81, 1, 0);
    // Reset on the same edge as a valid sample, then resume.
    drive(1, 8'hff, 1, 1);
    drive(1, 8'h85, 1, 0);
    drive(1, 8'h80, 1, 0);

    for (int i = 0; i < 1000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      m  = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0:       r = 8'h00;
        1, 2:    r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
      drive(v, r, m, rs);
    end

    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    check("q_drained", 32'(q.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
